// File: rtl/sram_multiport_ctrl_pkg.sv
// Shared types and constants for the multi-channel async-SRAM controller:
// FSM state encoding, byte-lane indices and the wait-counter width helper.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD       = 2'd1,
    WR_SETUP = 2'd2,
    WR_PULSE = 2'd3
  } sram_state_e;

  localparam int NUM_LANES = 2;
  localparam int LANE_LB   = 0;
  localparam int LANE_HB   = 1;

  // Wait counter must count 0..max(RD_WAIT,WR_WAIT); never narrower than 1 bit.
  function automatic int cnt_width(input int rd_wait, input int wr_wait);
    int m;
    m = (rd_wait > wr_wait) ? rd_wait : wr_wait;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_multiport_ctrl_if.sv
// Request/response bus between NUM_CH requesters and the SRAM controller.
// Per-channel fields are flattened, channel i occupying slice i of each vector.
interface sram_multiport_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [NUM_CH-1:0]           req;
  logic [NUM_CH-1:0]           we;
  logic [NUM_CH*ADDR_W-1:0]    addr;
  logic [NUM_CH*DATA_W-1:0]    wdata;
  logic [NUM_CH*NUM_LANES-1:0] be;
  logic [NUM_CH-1:0]           gnt;
  logic [NUM_CH-1:0]           rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/sram_multiport_ctrl_arbiter.sv
// Combinational channel picker: optional strict priority for ch0, otherwise
// round-robin starting at the pointer supplied by the parent.
module rr_arbiter #(
  parameter  int NUM_CH = 2,
  parameter  int PRIO0  = 1,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  function automatic int wrap(input int v);
    return (v >= NUM_CH) ? v - NUM_CH : v;
  endfunction

  // NOTE: every output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!valid && req[wrap(int'(ptr) + i)]) begin
        valid = 1'b1;
        idx   = IDX_W'(wrap(int'(ptr) + i));
      end
    end
    if (PRIO0 != 0 && req[0]) begin
      valid = 1'b1;
      idx   = '0;
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/sram_multiport_ctrl.sv
// Async-SRAM controller arbitrating NUM_CH channels onto one 16-bit port with
// programmable read/write wait states and byte-lane writes. All outputs registered.
module sram_multiport_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int PRIO0   = 1
) (
  input  logic                  clk100,
  input  logic                  rst_n,
  sram_multiport_ctrl_if.slave  bus,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_din,
  output logic [DATA_W-1:0]     ram_dout,
  output logic                  ram_ce,
  output logic                  ram_oe,
  output logic                  ram_we,
  output logic                  ram_lb,
  output logic                  ram_hb
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(RD_WAIT, WR_WAIT);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT);

  sram_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         ptr_q, sel_q;
  logic [NUM_LANES-1:0]     be_q;

  logic [NUM_CH-1:0]        win_oh;
  logic [IDX_W-1:0]         win_idx;
  logic                     win_valid;
  logic                     win_we;
  logic [NUM_LANES-1:0]     win_be;
  logic [ADDR_W-1:0]        win_addr;
  logic [DATA_W-1:0]        win_wdata;
  logic                     accept, start;

  logic [NUM_CH-1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]        rdata_q;
  logic [NUM_LANES-1:0]     lanes_d;
  logic                     ce_d, oe_d, we_d, lb_d, hb_d;

  rr_arbiter #(.NUM_CH(NUM_CH), .PRIO0(PRIO0)) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .grant (win_oh),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_we    = bus.we[win_idx];
  assign win_be    = bus.be[int'(win_idx)*NUM_LANES +: NUM_LANES];
  assign win_addr  = bus.addr[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_wdata = bus.wdata[int'(win_idx)*DATA_W +: DATA_W];

  // A write with no lanes enabled is granted but never touches the SRAM.
  assign accept = (state_q == IDLE) && win_valid;
  assign start  = accept && !(win_we && (win_be == '0));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = win_we ? WR_SETUP : RD;
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end
      WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-cycle values of the registered outputs, decoded from the state being entered.
  always_comb begin
    gnt_d    = accept ? win_oh : '0;
    rvalid_d = '0;
    if (state_q == RD && cnt_q == RD_LAST) rvalid_d[sel_q] = 1'b1;
    lanes_d  = (state_q == IDLE) ? win_be : be_q;
    ce_d = 1'b0;
    oe_d = 1'b0;
    we_d = 1'b0;
    lb_d = 1'b0;
    hb_d = 1'b0;
    unique case (state_d)
      RD: begin
        ce_d = 1'b1;
        oe_d = 1'b1;
        lb_d = 1'b1;
        hb_d = 1'b1;
      end
      WR_SETUP, WR_PULSE: begin
        ce_d = 1'b1;
        we_d = (state_d == WR_PULSE);
        lb_d = lanes_d[LANE_LB];
        hb_d = lanes_d[LANE_HB];
      end
      default: ;
    endcase
  end

  // NOTE: every register here has an explicit reset value; there is no storage array to leave unreset.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ram_addr <= '0;
      ram_dout <= '0;
      ram_ce   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_we   <= 1'b0;
      ram_lb   <= 1'b0;
      ram_hb   <= 1'b0;
      ptr_q    <= '0;
      sel_q    <= '0;
      be_q     <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      ram_ce   <= ce_d;
      ram_oe   <= oe_d;
      ram_we   <= we_d;
      ram_lb   <= lb_d;
      ram_hb   <= hb_d;
      if (rvalid_d != '0) rdata_q <= ram_din;
      if (accept) ptr_q <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
      if (start) begin
        sel_q    <= win_idx;
        be_q     <= win_be;
        ram_addr <= win_addr;
        if (win_we) ram_dout <= win_wdata;
      end
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_sram_multiport_ctrl.sv
// Directed bench for sram_multiport_ctrl: a 2-channel strict-priority instance
// and a 4-channel round-robin instance with different wait states.
module tb_sram_multiport_ctrl;

  logic clk100 = 1'b0;
  logic rst_n;
  always #5 clk100 = ~clk100;

  sram_multiport_ctrl_if #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16)) bus_a ();
  sram_multiport_ctrl_if #(.NUM_CH(4), .ADDR_W(18), .DATA_W(16)) bus_b ();

  logic [17:0] ram_addr_a, ram_addr_b;
  logic [15:0] din_a, din_b, dout_a, dout_b;
  logic ce_a, oe_a, we_a, lb_a, hb_a;
  logic ce_b, oe_b, we_b, lb_b, hb_b;
  logic [4:0] strb_a, strb_b;
  assign strb_a = {ce_a, oe_a, we_a, hb_a, lb_a};
  assign strb_b = {ce_b, oe_b, we_b, hb_b, lb_b};

  sram_multiport_ctrl #(.NUM_CH(2), .ADDR_W(18), .DATA_W(16),
                        .RD_WAIT(1), .WR_WAIT(1), .PRIO0(1)) u_dut_a (
    .clk100(clk100), .rst_n(rst_n), .bus(bus_a),
    .ram_addr(ram_addr_a), .ram_din(din_a), .ram_dout(dout_a),
    .ram_ce(ce_a), .ram_oe(oe_a), .ram_we(we_a), .ram_lb(lb_a), .ram_hb(hb_a)
  );

  sram_multiport_ctrl #(.NUM_CH(4), .ADDR_W(18), .DATA_W(16),
                        .RD_WAIT(0), .WR_WAIT(2), .PRIO0(0)) u_dut_b (
    .clk100(clk100), .rst_n(rst_n), .bus(bus_b),
    .ram_addr(ram_addr_b), .ram_din(din_b), .ram_dout(dout_b),
    .ram_ce(ce_b), .ram_oe(oe_b), .ram_we(we_b), .ram_lb(lb_b), .ram_hb(hb_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Strobe vectors are {ce, oe, we, hb, lb}.
  typedef struct {
    int          ch;
    logic        wr;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] din;
    logic [4:0]  s1, s2, s3, s4;
    logic [1:0]  rv3;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs[6];
  int   seq_b[8];
  int   got_b;
  int   g0, g1;

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One full single-channel access on instance A, checked cycle by cycle from C1 to C4.
  task automatic run_vec(input vec_t v, input int n);
    bus_a.req = '0;
    bus_a.req[v.ch] = 1'b1;
    bus_a.we[v.ch]  = v.wr;
    bus_a.addr[v.ch*18 +: 18]  = v.addr;
    bus_a.wdata[v.ch*16 +: 16] = v.wdata;
    bus_a.be[v.ch*2 +: 2]      = v.be;
    din_a = v.din;
    @(negedge clk100);
    check($sformatf("v%0d gnt", n), bus_a.gnt, 32'(1) << v.ch);
    check($sformatf("v%0d addr", n), ram_addr_a, v.addr);
    check($sformatf("v%0d strb C1", n), strb_a, v.s1);
    if (v.wr) check($sformatf("v%0d dout", n), dout_a, v.wdata);
    bus_a.req = '0;
    @(negedge clk100);
    check($sformatf("v%0d strb C2", n), strb_a, v.s2);
    check($sformatf("v%0d rvalid C2", n), bus_a.rvalid, 0);
    @(negedge clk100);
    check($sformatf("v%0d strb C3", n), strb_a, v.s3);
    check($sformatf("v%0d rvalid C3", n), bus_a.rvalid, v.rv3);
    if (!v.wr) check($sformatf("v%0d rdata", n), bus_a.rdata, v.rdata);
    @(negedge clk100);
    check($sformatf("v%0d strb C4", n), strb_a, v.s4);
  endtask

  task automatic collect_b(input int n);
    got_b = 0;
    for (int cyc = 0; cyc < 40 && got_b < n; cyc++) begin
      @(negedge clk100);
      if (bus_b.gnt != '0) begin
        seq_b[got_b] = oh_idx(bus_b.gnt);
        got_b++;
      end
    end
    check("grant count", got_b, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t rv;
    //        ch wr  addr        wdata     be     din       s1        s2        s3        s4        rv3    rdata
    vecs[0] = '{1, 1'b0, 18'h00123, 16'h0000, 2'b11, 16'hBEEF, 5'b11011, 5'b11011, 5'b00000, 5'b00000, 2'b10, 16'hBEEF};
    vecs[1] = '{0, 1'b1, 18'h3FFFF, 16'hA55A, 2'b10, 16'h0000, 5'b10010, 5'b10110, 5'b10110, 5'b00000, 2'b00, 16'h0000};
    vecs[2] = '{0, 1'b0, 18'h00000, 16'h0000, 2'b11, 16'h0001, 5'b11011, 5'b11011, 5'b00000, 5'b00000, 2'b01, 16'h0001};
    vecs[3] = '{1, 1'b1, 18'h12345, 16'h1234, 2'b01, 16'h0000, 5'b10001, 5'b10101, 5'b10101, 5'b00000, 2'b00, 16'h0000};
    vecs[4] = '{1, 1'b1, 18'h2AAAA, 16'hC3C3, 2'b11, 16'h0000, 5'b10011, 5'b10111, 5'b10111, 5'b00000, 2'b00, 16'h0000};
    vecs[5] = '{0, 1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'hFFFF, 5'b11011, 5'b11011, 5'b00000, 5'b00000, 2'b01, 16'hFFFF};

    rst_n = 1'b0;
    bus_a.req = '0; bus_a.we = '0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.be = '0;
    bus_b.req = '0; bus_b.we = '0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.be = '0;
    din_a = 16'h0000;
    din_b = 16'h0000;
    repeat (2) @(negedge clk100);
    check("reset strb a", strb_a, 0);
    check("reset gnt a", bus_a.gnt, 0);
    check("reset rvalid a", bus_a.rvalid, 0);
    check("reset rdata a", bus_a.rdata, 0);
    check("reset addr a", ram_addr_a, 0);
    check("reset dout a", dout_a, 0);
    check("reset strb b", strb_b, 0);
    check("reset gnt b", bus_b.gnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ch0 strict priority: with both channels hammering, ch1 never wins.
    bus_a.we = '0;
    bus_a.req = 2'b11;
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk100);
      if (bus_a.gnt[0]) g0++;
      if (bus_a.gnt[1]) g1++;
    end
    bus_a.req = '0;
    check("prio ch0 grants", g0, 4);
    check("prio ch1 grants", g1, 0);
    repeat (3) @(negedge clk100);

    // Null write (be=00): grant only, next read accepted on the following edge.
    bus_a.req[0] = 1'b1;
    bus_a.we[0] = 1'b1;
    bus_a.addr[0 +: 18] = 18'h00055;
    bus_a.be[0 +: 2] = 2'b00;
    @(negedge clk100);
    check("null wr gnt", bus_a.gnt, 2'b01);
    check("null wr strb", strb_a, 0);
    bus_a.req = 2'b10;
    bus_a.we = '0;
    bus_a.addr[18 +: 18] = 18'h00077;
    din_a = 16'h1357;
    @(negedge clk100);
    check("after null gnt", bus_a.gnt, 2'b10);
    check("after null strb", strb_a, 5'b11011);
    check("after null addr", ram_addr_a, 18'h00077);
    bus_a.req = '0;
    @(negedge clk100);
    @(negedge clk100);
    check("after null rvalid", bus_a.rvalid, 2'b10);
    check("after null rdata", bus_a.rdata, 16'h1357);
    @(negedge clk100);

    // Reset asserted mid write pulse: strobes drop without a clock edge.
    bus_a.req = 2'b01;
    bus_a.we = 2'b01;
    bus_a.addr[0 +: 18] = 18'h00100;
    bus_a.wdata[0 +: 16] = 16'h0F0F;
    bus_a.be[0 +: 2] = 2'b11;
    @(negedge clk100);
    bus_a.req = '0;
    @(negedge clk100);
    check("pre-reset pulse", strb_a, 5'b10111);
    #2 rst_n = 1'b0;
    #1 check("async reset strb", strb_a, 0);
    @(negedge clk100);
    rst_n = 1'b1;
    @(negedge clk100);
    check("post-reset strb", strb_a, 0);
    check("post-reset rvalid", bus_a.rvalid, 0);
    check("post-reset addr", ram_addr_a, 0);
    rv = '{1, 1'b0, 18'h0000A, 16'h0000, 2'b11, 16'h5A5A, 5'b11011, 5'b11011, 5'b00000, 5'b00000, 2'b10, 16'h5A5A};
    run_vec(rv, 6);

    // Round-robin instance: two requesters alternate.
    for (int i = 0; i < 4; i++) bus_b.addr[i*18 +: 18] = 18'h00100 + 18'(i);
    bus_b.we = '0;
    bus_b.req = 4'b0011;
    collect_b(4);
    bus_b.req = '0;
    check("rr2 g0", seq_b[0], 0);
    check("rr2 g1", seq_b[1], 1);
    check("rr2 g2", seq_b[2], 0);
    check("rr2 g3", seq_b[3], 1);
    repeat (2) @(negedge clk100);
    rst_n = 1'b0;
    @(negedge clk100);
    rst_n = 1'b1;

    // All four request from a fresh pointer, then ch2 alone.
    bus_b.req = 4'b1111;
    collect_b(5);
    bus_b.req = 4'b0100;
    check("rr4 g0", seq_b[0], 0);
    check("rr4 g1", seq_b[1], 1);
    check("rr4 g2", seq_b[2], 2);
    check("rr4 g3", seq_b[3], 3);
    check("rr4 g4", seq_b[4], 0);
    @(negedge clk100);
    check("ch2 idle gap", bus_b.gnt, 0);
    @(negedge clk100);
    check("ch2 alone gnt", bus_b.gnt, 4'b0100);
    check("ch2 alone addr", ram_addr_b, 18'h00102);
    bus_b.req = '0;
    repeat (2) @(negedge clk100);

    // Two extra write-pulse cycles on instance B, low lane only.
    bus_b.req = 4'b1000;
    bus_b.we = 4'b1000;
    bus_b.wdata[3*16 +: 16] = 16'h7E7E;
    bus_b.be[3*2 +: 2] = 2'b01;
    @(negedge clk100);
    bus_b.req = '0;
    check("wr2 setup", strb_b, 5'b10001);
    check("wr2 dout", dout_b, 16'h7E7E);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk100);
      check($sformatf("wr2 pulse %0d", i), strb_b, 5'b10101);
    end
    @(negedge clk100);
    check("wr2 done", strb_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
